// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline definitions: controller state encodings, scoreboard
// depth default and architectural register count.
package pipe_ctrl_pkg;
  localparam int NUM_REGS     = 16;
  localparam int SB_DEPTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_RSVD  = 2'd3
  } state_e;

  // Counter width able to hold the value 'depth'.
  function automatic int sb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sb_cnt.sv
// One scoreboard slot: loads DEPTH on issue, otherwise counts down to zero.
module sb_cnt #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_busy
);
  logic [W-1:0] r_cnt;

  // A load in the same cycle as a decrement takes priority.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)             r_cnt <= '0;
    else if (i_load)          r_cnt <= W'(DEPTH);
    else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign o_busy = (r_cnt != '0);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: RAW scoreboard over R0..R15 plus RUN/FLUSH/HALT FSM
// steering fetch enable, decode capture and decode-to-execute forwarding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WILLWRITE,
  input  logic [3:0] STARTREG,
  input  logic       READREG,
  input  logic [3:0] READREG1,
  input  logic [3:0] READREG2,
  input  logic       READ2V,
  input  logic       BRTAKEN,
  input  logic       HALTREQ,
  input  logic       RESUME,
  output logic       PCEN,
  output logic       STAGE2IN,
  output logic       STAGE2OUT,
  output logic       STALL,
  output logic [1:0] STATE
);
  localparam int CW = sb_cnt_w(SB_DEPTH);

  state_e              r_state;
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_load;
  logic                w_hazard;
  logic                w_issue;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
    assign w_load[g] = w_issue && (STARTREG == 4'(g));
    sb_cnt #(.DEPTH(SB_DEPTH), .W(CW)) u_cnt (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_load  (w_load[g]),
      .o_busy  (w_busy[g])
    );
  end

  assign w_hazard = READREG & (w_busy[READREG1] | (READ2V & w_busy[READREG2]));
  assign w_issue  = STAGE2OUT & WILLWRITE;

  // Outputs are forced quiet while reset is held so nothing issues.
  always_comb begin
    PCEN      = 1'b0;
    STAGE2IN  = 1'b0;
    STAGE2OUT = 1'b0;
    if (RST_N) begin
      case (r_state)
        ST_RUN: begin
          PCEN      = !w_hazard;
          STAGE2IN  = 1'b1;
          STAGE2OUT = !w_hazard & !BRTAKEN;
        end
        ST_FLUSH: PCEN = 1'b1;
        default: ;
      endcase
    end
  end

  assign STALL = RST_N & w_hazard & (r_state == ST_RUN);
  assign STATE = RST_N ? r_state : ST_RUN;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (BRTAKEN)      r_state <= ST_FLUSH;
          else if (HALTREQ) r_state <= ST_HALT;
        end
        ST_FLUSH: r_state <= ST_RUN;
        ST_HALT:  if (RESUME) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle vector table with expected
// outputs queued at drive time, plus a bounded stall-length sequence.
module tb_pipe_ctrl;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WILLWRITE = 1'b0, READREG = 1'b0, READ2V = 1'b0;
  logic       BRTAKEN = 1'b0, HALTREQ = 1'b0, RESUME = 1'b0;
  logic [3:0] STARTREG = '0, READREG1 = '0, READREG2 = '0;
  logic       PCEN, STAGE2IN, STAGE2OUT, STALL;
  logic [1:0] STATE;

  pipe_ctrl #(.SB_DEPTH(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .WILLWRITE(WILLWRITE), .STARTREG(STARTREG),
    .READREG(READREG), .READREG1(READREG1), .READREG2(READREG2),
    .READ2V(READ2V), .BRTAKEN(BRTAKEN), .HALTREQ(HALTREQ), .RESUME(RESUME),
    .PCEN(PCEN), .STAGE2IN(STAGE2IN), .STAGE2OUT(STAGE2OUT),
    .STALL(STALL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n, ww;
    logic [3:0] sr;
    logic       rr;
    logic [3:0] r1, r2;
    logic       r2v, br, halt, res;
    logic [5:0] exp; // {PCEN, STAGE2IN, STAGE2OUT, STALL, STATE[1:0]}
  } vec_t;

  localparam logic [5:0] E_RST = 6'b000000;
  localparam logic [5:0] E_RUN = 6'b111000;
  localparam logic [5:0] E_STL = 6'b010100;
  localparam logic [5:0] E_BR  = 6'b110000;
  localparam logic [5:0] E_FL  = 6'b100001;
  localparam logic [5:0] E_HLT = 6'b000010;

  int checks = 0;
  int failures = 0;
  vec_t vt[$];
  logic [5:0] exp_q[$];

  function automatic vec_t mk(input logic rst_n, ww, input logic [3:0] sr,
                              input logic rr, input logic [3:0] r1, r2,
                              input logic r2v, br, halt, res,
                              input logic [5:0] exp);
    vec_t v;
    v.rst_n = rst_n; v.ww = ww; v.sr = sr; v.rr = rr; v.r1 = r1; v.r2 = r2;
    v.r2v = r2v; v.br = br; v.halt = halt; v.res = res; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    RST_N = v.rst_n; WILLWRITE = v.ww; STARTREG = v.sr; READREG = v.rr;
    READREG1 = v.r1; READREG2 = v.r2; READ2V = v.r2v; BRTAKEN = v.br;
    HALTREQ = v.halt; RESUME = v.res;
  endtask

  task automatic chk1(input string name, input int idx, input logic [1:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic compare(input int idx, input logic [5:0] e);
    chk1("PCEN",      idx, {1'b0, PCEN},      {1'b0, e[5]});
    chk1("STAGE2IN",  idx, {1'b0, STAGE2IN},  {1'b0, e[4]});
    chk1("STAGE2OUT", idx, {1'b0, STAGE2OUT}, {1'b0, e[3]});
    chk1("STALL",     idx, {1'b0, STALL},     {1'b0, e[2]});
    chk1("STATE",     idx, STATE,             e[1:0]);
  endtask

  initial begin
    int n_stall;
    bit released;

    // reset, issue blocked
    vt.push_back(mk(0,1,1,0,0,0,0,0,0,0,E_RST));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,E_RST));
    // ADD R1 ; ADD R2,R1,R3 -> 3 stall cycles, issues on 4th
    vt.push_back(mk(1,1,1,1,2,3,1,0,0,0,E_RUN));
    vt.push_back(mk(1,1,2,1,1,3,1,0,0,0,E_STL));
    vt.push_back(mk(1,1,2,1,1,3,1,0,0,0,E_STL));
    vt.push_back(mk(1,1,2,1,1,3,1,0,0,0,E_STL));
    vt.push_back(mk(1,1,2,1,1,3,1,0,0,0,E_RUN));
    // independent stream R1, R2 (reload while draining), R4
    vt.push_back(mk(1,1,1,1,5,6,1,0,0,0,E_RUN));
    vt.push_back(mk(1,1,2,1,7,8,1,0,0,0,E_RUN));
    vt.push_back(mk(1,1,4,1,9,10,1,0,0,0,E_RUN));
    // SW R5 with READREG2=busy R1 but READ2V=0 -> no stall
    vt.push_back(mk(1,0,0,1,5,1,0,0,0,0,E_RUN));
    // READ2V=1 on busy R4 (cnt 2) -> stall 2 cycles
    vt.push_back(mk(1,0,0,1,5,4,1,0,0,0,E_STL));
    vt.push_back(mk(1,0,0,1,5,4,1,0,0,0,E_STL));
    vt.push_back(mk(1,0,0,1,5,4,1,0,0,0,E_RUN));
    // branch in RUN; writer in decode must not mark R6
    vt.push_back(mk(1,1,6,0,0,0,0,1,0,0,E_BR));
    vt.push_back(mk(1,1,6,0,0,0,0,0,0,0,E_FL));
    vt.push_back(mk(1,0,0,1,6,0,0,0,0,0,E_RUN));
    // branch while stalled on R1; R3 never issued
    vt.push_back(mk(1,1,1,1,0,0,1,0,0,0,E_RUN));
    vt.push_back(mk(1,1,3,1,1,0,0,0,0,0,E_STL));
    vt.push_back(mk(1,1,3,1,1,0,0,1,0,0,E_STL));
    vt.push_back(mk(1,1,3,1,1,0,0,0,0,0,E_FL));
    vt.push_back(mk(1,0,0,1,3,1,1,0,0,0,E_RUN));
    // halt: 5 idle cycles, resume, scoreboard drained
    vt.push_back(mk(1,1,7,0,0,0,0,0,1,0,E_RUN));
    for (int k = 0; k < 5; k++) vt.push_back(mk(1,1,8,1,7,0,0,0,0,0,E_HLT));
    vt.push_back(mk(1,1,8,1,7,0,0,0,0,1,E_HLT));
    vt.push_back(mk(1,0,0,1,7,8,1,0,0,0,E_RUN));
    // reset mid-stall
    vt.push_back(mk(1,1,9,0,0,0,0,0,0,0,E_RUN));
    vt.push_back(mk(1,0,0,1,9,0,0,0,0,0,E_STL));
    vt.push_back(mk(0,0,0,1,9,0,0,0,0,0,E_RST));
    vt.push_back(mk(1,0,0,1,9,0,0,0,0,0,E_RUN));
    // reset mid-flush
    vt.push_back(mk(1,0,0,0,0,0,0,1,0,0,E_BR));
    vt.push_back(mk(0,0,0,0,0,0,0,0,0,0,E_RST));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,0,E_RUN));
    // BRTAKEN beats HALTREQ
    vt.push_back(mk(1,0,0,0,0,0,0,1,1,0,E_BR));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,0,E_FL));
    vt.push_back(mk(1,0,0,0,0,0,0,0,0,0,E_RUN));

    apply(vt[0]);
    for (int i = 0; i < vt.size(); i++) begin
      @(posedge CLK); #1;
      apply(vt[i]);
      exp_q.push_back(vt[i].exp);
      @(negedge CLK);
      compare(i, exp_q.pop_front());
    end

    // stall length on a fresh writer of R5, bounded wait for release
    @(posedge CLK); #1;
    apply(mk(1,1,5,0,0,0,0,0,0,0,E_RUN));
    @(posedge CLK); #1;
    apply(mk(1,1,2,1,5,0,0,0,0,0,E_RUN));
    n_stall = 0;
    released = 0;
    for (int c = 0; c < 8 && !released; c++) begin
      @(negedge CLK);
      if (STALL) begin
        n_stall++;
        @(posedge CLK); #1;
      end else begin
        released = 1;
      end
    end
    checks++;
    if (!released) begin
      failures++;
      $display("FAIL stall_release: still stalled after 8 cycles, expected release");
    end
    checks++;
    if (n_stall != 3) begin
      failures++;
      $display("FAIL stall_len: got %0d cycles expected 3", n_stall);
    end
    checks++;
    if (STAGE2OUT !== 1'b1) begin
      failures++;
      $display("FAIL stall_issue: STAGE2OUT got %0b expected 1", STAGE2OUT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter SB_DEPTH, default 3, meaning the cycles from issue out of decode to register-file writeback.
REQ-002 The block SHALL have port CLK, input, 1, the single system clock; all state updates on posedge CLK.
REQ-003 The block SHALL have port RST_N, input, 1, reset; it is synchronous and active-low.
REQ-004 The block SHALL have port WILLWRITE, input, 1, decode instruction writes STARTREG.
REQ-005 The block SHALL have port STARTREG, input, 4, decode destination register.
REQ-006 The block SHALL have port READREG, input, 1, decode instruction reads source registers.
REQ-007 The block SHALL have ports READREG1 and READREG2, input, 4 each, decode source registers.
REQ-008 The block SHALL have port READ2V, input, 1, READREG2 is meaningful (R-type, BEQ).
REQ-009 The block SHALL have port BRTAKEN, input, 1, execute stage resolved a taken BEQ or JUMP this cycle.
REQ-010 The block SHALL have port HALTREQ, input, 1, writeback retired a halt instruction.
REQ-011 The block SHALL have port RESUME, input, 1, external restart from HALT.
REQ-012 The block SHALL have port PCEN, output, 1, fetch may advance PC and IR.
REQ-013 The block SHALL have port STAGE2IN, output, 1, decode captures fetched IR/PC (else captures zero).
REQ-014 The block SHALL have port STAGE2OUT, output, 1, decode forwards its result to execute (else a bubble).
REQ-015 The block SHALL have port STALL, output, 1, RAW hazard detected this cycle.
REQ-016 The block SHALL have port STATE, output, 2, current FSM state, for debug.

Function
REQ-017 The scoreboard SHALL hold one counter per register R0..R15, each ceil(log2(SB_DEPTH+1)) bits wide; register r is busy iff cnt[r] != 0.
REQ-018 Hazard SHALL be READREG & (busy[READREG1] | (READ2V & busy[READREG2])); STALL = hazard & (state==RUN); STALL is combinational, valid before negedge.
REQ-019 Issue SHALL be STAGE2OUT & WILLWRITE; on issue, cnt[STARTREG] loads SB_DEPTH at posedge.
REQ-020 Every other nonzero counter SHALL decrement by 1 per cycle, saturating at 0; on a load to a counter that is also decrementing, the load wins.
REQ-021 The FSM SHALL have states RUN=0, FLUSH=1, HALT=2, and 3 unused (recovers to RUN).
REQ-022 In RUN the outputs SHALL be PCEN=!hazard, STAGE2IN=1, STAGE2OUT=!hazard & !BRTAKEN.
REQ-023 In RUN, BRTAKEN SHALL move the FSM to FLUSH; otherwise HALTREQ SHALL move it to HALT; if both, BRTAKEN wins.
REQ-024 In FLUSH (exactly 1 cycle) the outputs SHALL be PCEN=1 (fetch the target), STAGE2IN=0, STAGE2OUT=0, then the FSM returns to RUN.
REQ-025 In HALT the outputs SHALL be PCEN=0, STAGE2IN=0, STAGE2OUT=0; the scoreboard keeps draining; RESUME returns the FSM to RUN.
REQ-026 A stall SHALL last until the blocking counter reaches 0, at most SB_DEPTH cycles; fetch holds IR so decode re-decodes the same instruction.
REQ-027 BRTAKEN during a stall SHALL win: the flush proceeds and the stalled instruction is discarded (no issue).
REQ-028 A bubble or flush SHALL never set a scoreboard counter.

Reset
REQ-029 With RST_N low at posedge, the block SHALL set FSM=RUN and all counters=0.
REQ-030 During reset the outputs SHALL be PCEN=0, STAGE2IN=0, STAGE2OUT=0, STALL=0, STATE=0.
REQ-031 Reset mid-stall or mid-flush SHALL abort the operation with no residual busy bits.

Structure
REQ-032 The state encodings, SB_DEPTH default and register count 16 SHALL live in the shared CPU definitions include, alongside the opcode and field macros.
REQ-033 The per-register counter SHALL be one sub-module, sb_cnt (load/decrement/busy), instantiated 16 times.

Verification
REQ-034 The bench SHALL cover back-to-back dependency: ADD R1 then ADD R2,R1,R3 -> STALL high 3 cycles, STAGE2OUT low 3 cycles, second ADD issues on cycle 4.
REQ-035 The bench SHALL cover the independent stream: ADD R1, ADD R2, ADD R4 with no overlap -> STALL never asserted, PCEN constant 1.
REQ-036 The bench SHALL cover SW reading R5 with READ2V=0 and READREG2=busy R1 -> no stall.
REQ-037 The bench SHALL cover BRTAKEN in RUN -> next cycle STATE=1, STAGE2IN=0, STAGE2OUT=0, PCEN=1; the following cycle STATE=0.
REQ-038 The bench SHALL cover BRTAKEN while stalled on R1 -> flush taken, cnt[STARTREG] unchanged, stall cleared.
REQ-039 The bench SHALL cover HALTREQ, then 5 idle cycles, then RESUME -> PCEN=0 throughout HALT, all counters 0 at resume, RUN next cycle; RST_N low during a stall clears STALL next cycle.
